// File: rtl/open_list_pkg.sv
// Shared definitions for the A* open-list priority queue: default field
// widths, packet field offsets, the head FSM state type and the ordering rule.
package open_list_pkg;

    localparam int DEF_COL_W  = 4;
    localparam int DEF_ROW_W  = 4;
    localparam int DEF_CELL_W = DEF_COL_W + DEF_ROW_W + 1;
    localparam int DEF_F_W    = 8;
    localparam int DEF_H_W    = 7;
    localparam int DEF_G_W    = 7;
    localparam int DEF_DATA_W = DEF_F_W + DEF_H_W + DEF_G_W + DEF_CELL_W;
    localparam int DEF_DEPTH  = 16;
    localparam int DEF_NUM_IN = 4;

    // Packet layout {f, h, g, row, col, valid}, valid in bit 0.
    localparam int VALID_BIT = 0;
    localparam int COL_LSB   = 1;
    localparam int ROW_LSB   = COL_LSB + DEF_COL_W;
    localparam int G_LSB     = DEF_CELL_W;
    localparam int H_LSB     = G_LSB + DEF_G_W;
    localparam int F_LSB     = H_LSB + DEF_H_W;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        REFRESH = 2'd1,
        READY   = 2'd2
    } state_t;

    // True when entry a outranks entry b: lower f, then lower h, then lower slot.
    function automatic logic better(input logic [31:0] fa, input logic [31:0] ha,
                                    input logic [31:0] ia, input logic [31:0] fb,
                                    input logic [31:0] hb, input logic [31:0] ib);
        if (fa != fb) return fa < fb;
        if (ha != hb) return ha < hb;
        return ia < ib;
    endfunction

endpackage

// File: rtl/open_list_pq_if.sv
// Handshake bundle between the open-list queue and its client.
interface open_list_pq_if
    import open_list_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int NUM_IN = DEF_NUM_IN,
    parameter int CNT_W  = $clog2(DEF_DEPTH + 1)
);
    logic                           flush;
    logic                           push;
    logic [NUM_IN-1:0][DATA_W-1:0]  in_pkt;
    logic                           pop;
    logic                           head_valid;
    logic [DATA_W-1:0]              head_pkt;
    logic [CNT_W-1:0]               count;
    logic                           empty;
    logic                           full;
    logic                           overflow;

    modport master (
        output flush, push, in_pkt, pop,
        input  head_valid, head_pkt, count, empty, full, overflow
    );

    modport slave (
        input  flush, push, in_pkt, pop,
        output head_valid, head_pkt, count, empty, full, overflow
    );
endinterface

// File: rtl/pq_argmin.sv
// Combinational tournament tree selecting the best valid slot by (f, h, index).
module pq_argmin
    import open_list_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int F_W   = DEF_F_W,
    parameter int H_W   = DEF_H_W,
    parameter int IDX_W = $clog2(DEPTH)
)(
    input  logic [DEPTH-1:0]          vld,
    input  logic [DEPTH-1:0][F_W-1:0] f,
    input  logic [DEPTH-1:0][H_W-1:0] h,
    output logic [IDX_W-1:0]          idx,
    output logic                      found
);
    localparam int LEAVES = 1 << $clog2(DEPTH);

    // Heap-numbered tree: leaves at LEAVES..2*LEAVES-1, root at node 1.
    // The left child always carries lower slot indices, so ties favour it.
    always_comb begin : tree
        logic             n_vld [2*LEAVES];
        logic [F_W-1:0]   n_f   [2*LEAVES];
        logic [H_W-1:0]   n_h   [2*LEAVES];
        logic [IDX_W-1:0] n_idx [2*LEAVES];
        for (int n = 0; n < 2*LEAVES; n++) begin
            n_vld[n] = 1'b0;
            n_f[n]   = '0;
            n_h[n]   = '0;
            n_idx[n] = '0;
        end
        for (int i = 0; i < LEAVES; i++) begin
            if (i < DEPTH) begin
                n_vld[LEAVES+i] = vld[i];
                n_f[LEAVES+i]   = f[i];
                n_h[LEAVES+i]   = h[i];
                n_idx[LEAVES+i] = IDX_W'(i);
            end
        end
        for (int n = LEAVES - 1; n >= 1; n--) begin
            if (n_vld[2*n] && (!n_vld[2*n+1] ||
                better(32'(n_f[2*n]), 32'(n_h[2*n]), 32'(n_idx[2*n]),
                       32'(n_f[2*n+1]), 32'(n_h[2*n+1]), 32'(n_idx[2*n+1])))) begin
                n_vld[n] = n_vld[2*n];
                n_f[n]   = n_f[2*n];
                n_h[n]   = n_h[2*n];
                n_idx[n] = n_idx[2*n];
            end else begin
                n_vld[n] = n_vld[2*n+1];
                n_f[n]   = n_f[2*n+1];
                n_h[n]   = n_h[2*n+1];
                n_idx[n] = n_idx[2*n+1];
            end
        end
        idx   = n_idx[1];
        found = n_vld[1];
    end

endmodule

// File: rtl/open_list_pq.sv
// Open-list priority queue for the A* datapath: fixed slot storage,
// multi-lane insert with decrease-key, registered lowest-cost head with pop.
//
// state   | meaning
// EMPTY   | no valid entries, head_valid=0
// REFRESH | slots changed last edge, head being recomputed, head_valid=0
// READY   | head_pkt holds the best entry, head_valid=1
module open_list_pq
    import open_list_pkg::*;
#(
    parameter int CELL_COL_W = DEF_COL_W,
    parameter int CELL_ROW_W = DEF_ROW_W,
    parameter int CELL_W     = CELL_COL_W + CELL_ROW_W + 1,
    parameter int F_W        = DEF_F_W,
    parameter int H_W        = DEF_H_W,
    parameter int G_W        = DEF_G_W,
    parameter int DATA_W     = F_W + H_W + G_W + CELL_W,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int NUM_IN     = DEF_NUM_IN,
    parameter int CNT_W      = $clog2(DEPTH + 1)
)(
    input  logic           clk,
    input  logic           rst_n,
    open_list_pq_if.slave  bus
);
    localparam int OFS_G = CELL_W;
    localparam int OFS_H = OFS_G + G_W;
    localparam int OFS_F = OFS_H + H_W;
    localparam int IDX_W = $clog2(DEPTH);

    logic [DEPTH-1:0][DATA_W-1:0] slots, slots_nxt;
    logic [DEPTH-1:0]             key_vld;
    logic [DEPTH-1:0][F_W-1:0]    key_f;
    logic [DEPTH-1:0][H_W-1:0]    key_h;
    logic [IDX_W-1:0]             win_idx;
    logic                         win_found;
    state_t                       state, state_nxt;
    logic [DATA_W-1:0]            head_q;
    logic [IDX_W-1:0]             head_idx;
    logic [CNT_W-1:0]             count_q, count_nxt;
    logic                         overflow_q;
    logic                         ovf_set;
    logic                         changed;
    logic                         pop_acc;

    // Slice sort keys out of each slot for the argmin tree.
    always_comb begin
        for (int j = 0; j < DEPTH; j++) begin
            key_vld[j] = slots[j][0];
            key_f[j]   = slots[j][OFS_F +: F_W];
            key_h[j]   = slots[j][OFS_H +: H_W];
        end
    end

    pq_argmin #(
        .DEPTH (DEPTH),
        .F_W   (F_W),
        .H_W   (H_W),
        .IDX_W (IDX_W)
    ) u_argmin (
        .vld   (key_vld),
        .f     (key_f),
        .h     (key_h),
        .idx   (win_idx),
        .found (win_found)
    );

    // Next slot contents: lane inserts / in-place decrease-key, then pop.
    // Free slots are judged on pre-edge validity, so a popped slot stays
    // unusable this cycle; pop last so it wins over an update to the head.
    always_comb begin : ins
        logic [DEPTH-1:0] taken;
        logic             hit;
        logic             placed;
        logic [IDX_W-1:0] hit_idx;
        slots_nxt = slots;
        changed   = 1'b0;
        ovf_set   = 1'b0;
        hit       = 1'b0;
        placed    = 1'b0;
        hit_idx   = '0;
        for (int j = 0; j < DEPTH; j++) taken[j] = slots[j][0];
        for (int l = 0; l < NUM_IN; l++) begin
            hit     = 1'b0;
            placed  = 1'b0;
            hit_idx = '0;
            if (bus.push && bus.in_pkt[l][0]) begin
                for (int j = 0; j < DEPTH; j++) begin
                    if (slots[j][0] && slots[j][CELL_W-1:1] == bus.in_pkt[l][CELL_W-1:1]) begin
                        hit     = 1'b1;
                        hit_idx = IDX_W'(j);
                    end
                end
                if (hit) begin
                    if (bus.in_pkt[l][OFS_F +: F_W] < slots[hit_idx][OFS_F +: F_W]) begin
                        slots_nxt[hit_idx] = bus.in_pkt[l];
                        changed            = 1'b1;
                    end
                end else begin
                    for (int j = 0; j < DEPTH; j++) begin
                        if (!placed && !taken[j]) begin
                            slots_nxt[j] = bus.in_pkt[l];
                            taken[j]     = 1'b1;
                            placed       = 1'b1;
                            changed      = 1'b1;
                        end
                    end
                    if (!placed) ovf_set = 1'b1;
                end
            end
        end
        pop_acc = bus.pop && (state == READY);
        if (pop_acc) slots_nxt[head_idx][0] = 1'b0;
    end

    // Occupancy after this edge's updates.
    always_comb begin
        count_nxt = '0;
        for (int j = 0; j < DEPTH; j++) count_nxt = count_nxt + CNT_W'(slots_nxt[j][0]);
    end

    // Slot storage, occupancy and sticky overflow; flush overrides everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slots      <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else if (bus.flush) begin
            slots      <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            slots   <= slots_nxt;
            count_q <= count_nxt;
            if (ovf_set) overflow_q <= 1'b1;
        end
    end

    // Head FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= EMPTY;
        else        state <= state_nxt;
    end

    // Head FSM next state: any slot change restarts the head computation.
    always_comb begin
        state_nxt = state;
        if (bus.flush)                 state_nxt = EMPTY;
        else if (changed || pop_acc)   state_nxt = REFRESH;
        else if (state == REFRESH)     state_nxt = (count_q != '0) ? READY : EMPTY;
    end

    // Capture the argmin winner while refreshing; it stays put until the next change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q   <= '0;
            head_idx <= '0;
        end else if (bus.flush) begin
            head_q   <= '0;
            head_idx <= '0;
        end else if (state == REFRESH) begin
            head_q   <= win_found ? slots[win_idx] : '0;
            head_idx <= win_idx;
        end
    end

    assign bus.head_valid = (state == READY);
    assign bus.head_pkt   = head_q;
    assign bus.count      = count_q;
    assign bus.empty      = (count_q == '0);
    assign bus.full       = (count_q == CNT_W'(DEPTH));
    assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_open_list_pq.sv
// Directed bench for open_list_pq with hand-computed expectations.
module tb_open_list_pq;
    import open_list_pkg::*;

    localparam int DATA_W = DEF_DATA_W;
    localparam int NUM_IN = 4;
    localparam int DEPTH  = 16;
    localparam int CNT_W  = $clog2(DEPTH + 1);

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    open_list_pq_if #(.DATA_W(DATA_W), .NUM_IN(NUM_IN), .CNT_W(CNT_W)) bus ();

    open_list_pq #(.DEPTH(DEPTH), .NUM_IN(NUM_IN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] mk(input int f, input int h, input int g,
                                             input int row, input int col);
        logic [DATA_W-1:0] p;
        p = '0;
        p[F_LSB +: DEF_F_W]   = DEF_F_W'(f);
        p[H_LSB +: DEF_H_W]   = DEF_H_W'(h);
        p[G_LSB +: DEF_G_W]   = DEF_G_W'(g);
        p[ROW_LSB +: DEF_ROW_W] = DEF_ROW_W'(row);
        p[COL_LSB +: DEF_COL_W] = DEF_COL_W'(col);
        p[VALID_BIT]          = 1'b1;
        return p;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        bus.push   = 1'b0;
        bus.pop    = 1'b0;
        bus.flush  = 1'b0;
        bus.in_pkt = '0;
    endtask

    task automatic do_flush();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
    endtask

    // Sixteen distinct cells (k,l) with f = 100 + 4k + l, one push per row.
    task automatic fill_all();
        for (int k = 0; k < 4; k++) begin
            for (int l = 0; l < NUM_IN; l++) bus.in_pkt[l] = mk(100 + 4*k + l, 1, 0, k, l);
            bus.push = 1'b1;
            tick();
        end
        idle_in();
    endtask

    initial begin
        idle_in();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", bus.count, 0);
        chk("rst_empty", bus.empty, 1);
        chk("rst_full", bus.full, 0);
        chk("rst_overflow", bus.overflow, 0);
        chk("rst_head_valid", bus.head_valid, 0);
        chk("rst_head_pkt", bus.head_pkt, 0);
        rst_n = 1'b1;
        tick();

        // Basic ordering: f ties broken by h; invalid lane ignored.
        bus.in_pkt[0] = mk(20, 9, 0, 0, 1);
        bus.in_pkt[1] = mk(15, 7, 0, 0, 2);
        bus.in_pkt[2] = mk(15, 5, 0, 0, 3);
        bus.in_pkt[3] = '0;
        bus.push = 1'b1;
        tick();
        idle_in();
        chk("t1_count", bus.count, 3);
        chk("t1_refresh_hv", bus.head_valid, 0);
        tick();
        chk("t1_head_valid", bus.head_valid, 1);
        chk("t1_head_pkt", bus.head_pkt, mk(15, 5, 0, 0, 3));

        do_flush();
        chk("fl_count", bus.count, 0);
        chk("fl_empty", bus.empty, 1);
        chk("fl_head_valid", bus.head_valid, 0);

        // Decrease-key on duplicate cell.
        bus.in_pkt[0] = mk(30, 2, 1, 3, 4);
        bus.push = 1'b1;
        tick();
        idle_in();
        tick();
        chk("dk_head_30", bus.head_pkt, mk(30, 2, 1, 3, 4));
        bus.in_pkt[0] = mk(25, 2, 1, 3, 4);
        bus.push = 1'b1;
        tick();
        idle_in();
        chk("dk_count", bus.count, 1);
        chk("dk_refresh_hv", bus.head_valid, 0);
        tick();
        chk("dk_head_25", bus.head_pkt, mk(25, 2, 1, 3, 4));
        bus.in_pkt[0] = mk(40, 2, 1, 3, 4);
        bus.push = 1'b1;
        tick();
        idle_in();
        chk("dk_hi_hv", bus.head_valid, 1);
        chk("dk_hi_count", bus.count, 1);
        tick();
        chk("dk_hi_head", bus.head_pkt, mk(25, 2, 1, 3, 4));

        // Fill to capacity, then overflow.
        do_flush();
        fill_all();
        chk("fill_count", bus.count, 16);
        chk("fill_full", bus.full, 1);
        chk("fill_ovf0", bus.overflow, 0);
        bus.in_pkt[0] = mk(5, 0, 0, 9, 9);
        bus.in_pkt[1] = mk(6, 0, 0, 9, 10);
        bus.push = 1'b1;
        tick();
        idle_in();
        chk("ovf_count", bus.count, 16);
        chk("ovf_full", bus.full, 1);
        chk("ovf_set", bus.overflow, 1);
        repeat (3) tick();
        chk("ovf_sticky", bus.overflow, 1);
        chk("ovf_head", bus.head_pkt, mk(100, 1, 0, 0, 0));
        do_flush();
        chk("ovf_flush", bus.overflow, 0);

        // Push and pop together at full: pop applied, lane dropped.
        fill_all();
        tick();
        chk("pp_ready", bus.head_valid, 1);
        bus.in_pkt[0] = mk(1, 0, 0, 9, 9);
        bus.push = 1'b1;
        bus.pop  = 1'b1;
        tick();
        idle_in();
        chk("pp_count", bus.count, 15);
        chk("pp_ovf", bus.overflow, 1);
        chk("pp_hv", bus.head_valid, 0);
        tick();
        chk("pp_head", bus.head_pkt, mk(101, 1, 0, 0, 1));

        // Index tie-break: equal f/h in slots 2 and 5.
        do_flush();
        bus.in_pkt[0] = mk(200, 3, 0, 1, 0);
        bus.in_pkt[1] = mk(200, 3, 0, 1, 1);
        bus.in_pkt[2] = mk(200, 3, 1, 1, 2);
        bus.in_pkt[3] = mk(200, 3, 0, 1, 3);
        bus.push = 1'b1;
        tick();
        bus.in_pkt[0] = mk(200, 3, 0, 2, 0);
        bus.in_pkt[1] = mk(10, 3, 2, 2, 1);
        bus.in_pkt[2] = mk(200, 3, 0, 2, 2);
        bus.in_pkt[3] = mk(200, 3, 0, 2, 3);
        tick();
        idle_in();
        bus.in_pkt[0] = mk(10, 3, 1, 1, 2);
        bus.push = 1'b1;
        tick();
        idle_in();
        tick();
        chk("tie_hv", bus.head_valid, 1);
        chk("tie_head_slot2", bus.head_pkt, mk(10, 3, 1, 1, 2));
        bus.pop = 1'b1;
        tick();
        chk("tie_pop_hv", bus.head_valid, 0);
        chk("tie_pop_count", bus.count, 7);
        tick();
        bus.pop = 1'b0;
        chk("tie_ignored_pop_count", bus.count, 7);
        chk("tie_next_hv", bus.head_valid, 1);
        chk("tie_head_slot5", bus.head_pkt, mk(10, 3, 2, 2, 1));

        // In-place update of the head cell while popping it: pop wins.
        bus.in_pkt[0] = mk(5, 3, 2, 2, 1);
        bus.push = 1'b1;
        bus.pop  = 1'b1;
        tick();
        idle_in();
        chk("upd_pop_count", bus.count, 6);
        tick();
        chk("upd_pop_head", bus.head_pkt, mk(200, 3, 0, 1, 0));

        // Flush beats push.
        bus.flush = 1'b1;
        bus.push  = 1'b1;
        bus.in_pkt[0] = mk(50, 0, 0, 5, 5);
        tick();
        idle_in();
        chk("fp_count", bus.count, 0);
        chk("fp_empty", bus.empty, 1);
        chk("fp_hv", bus.head_valid, 0);
        chk("fp_ovf", bus.overflow, 0);

        // Asynchronous reset during REFRESH.
        bus.in_pkt[0] = mk(50, 0, 0, 5, 5);
        bus.push = 1'b1;
        tick();
        idle_in();
        tick();
        bus.in_pkt[0] = mk(60, 0, 0, 6, 6);
        bus.push = 1'b1;
        tick();
        idle_in();
        chk("ar_pre_count", bus.count, 2);
        chk("ar_pre_head", bus.head_pkt, mk(50, 0, 0, 5, 5));
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_count", bus.count, 0);
        chk("ar_empty", bus.empty, 1);
        chk("ar_hv", bus.head_valid, 0);
        chk("ar_head", bus.head_pkt, 0);
        chk("ar_full", bus.full, 0);
        chk("ar_ovf", bus.overflow, 0);
        tick();
        rst_n = 1'b1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/open_list_pq.md
# open_list_pq

- Parametrised, synthesizable open-list priority queue for the A* search datapath.
- Holds up to DEPTH candidate cells, each with f, h and g scores.
- Each cycle it accepts up to NUM_IN neighbour packets (N, E, S, W by default) and presents the lowest-cost entry through a registered head with a pop handshake.
- Beyond a simple queue, it adds fixed-depth storage, decrease-key on duplicate cells, overflow reporting, flush and per-entry g tracking.

## Interface
- CELL_COL_W, 4, column index width
- CELL_ROW_W, 4, row index width
- CELL_W, CELL_COL_W+CELL_ROW_W+1, cell field = {row, col, valid}; valid is bit 0
- F_W, 8, f-score width
- H_W, 7, h-score width
- G_W, 7, g-score width
- DATA_W, F_W+H_W+G_W+CELL_W, packet = {f, h, g, row, col, valid}, f in the MSBs
- DEPTH, 16, storage entries (≥2)
- NUM_IN, 4, insert lanes; lane 0 has the highest priority
- CNT_W, $clog2(DEPTH+1), occupancy width
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous clear of all entries
- push  in  1  insert strobe; lane i participates when push=1 and in_pkt[i][0]=1
- in_pkt  in  NUM_IN×DATA_W  insert packets
- pop  in  1  removes the head when head_valid=1
- head_valid  out  1  head_pkt is valid and poppable
- head_pkt  out  DATA_W  lowest-cost entry
- count  out  CNT_W  number of valid entries
- empty / full  out  1  count==0 / count==DEPTH
- overflow  out  1  sticky; a valid lane was dropped; cleared only by flush or reset

## Operation
- Storage is DEPTH slots, each a DATA_W register with the valid bit in bit 0.
- **Ordering:** entry A beats entry B if A.f<B.f, or f is equal and A.h<B.h, or both are equal and A has the lower slot index.
- **Insert:**
  - Lanes are processed 0..NUM_IN-1.
  - If a valid slot already holds the same {row, col}:
    - Replace that slot in place when the new f is strictly lower.
    - Otherwise discard the lane silently.
  - Otherwise, write the lane to the lowest-index free slot, based on slots free before this edge.
  - Lanes in one push carry distinct cells. Duplicates within a single push are undefined and are not checked.
  - A new cell with no free slot is dropped and sets overflow. Lower lanes still take their slots.
- **Pop:** when pop=1 and head_valid=1, invalidate the slot head_pkt came from. pop while head_valid=0 is ignored.
- **Push and pop in the same cycle:**
  - Both are applied.
  - The slot freed by the pop is not reusable in that cycle.
  - If an insert updates the head's cell in place, the pop removes that slot, discarding the update.
- **flush:** invalidates all slots and clears overflow. It has priority over push and pop in the same cycle.
- **FSM states:**
  - EMPTY: count==0.
  - REFRESH: head being recomputed; head_valid=0.
  - READY: head_valid=1.
- **FSM transitions:**
  - Any accepted push, pop or in-place update goes to REFRESH the next cycle.
  - REFRESH goes to READY if count>0, else EMPTY.
  - READY or EMPTY with no change holds its state.
  - flush goes to EMPTY.
- **Arithmetic:** comparisons are unsigned. Scores are stored as received, with no saturation or increment inside the block.

## Timing
- **Reset values:** all slots invalid, state EMPTY, head_valid=0, head_pkt=0, count=0, empty=1, full=0, overflow=0. Reset asserted mid-operation discards everything asynchronously.
- **count, empty, full, overflow:** registered; they reflect an edge's insert/pop/flush in the cycle after that edge.
- **Head latency:**
  - A push at edge k gives head_valid=0 during cycle k+1 (REFRESH).
  - head_pkt is registered at edge k+1 and valid from cycle k+2.
- **Pop throughput:** one pop every two cycles at most.
- **Back-to-back pushes:** hold REFRESH; head_valid rises one cycle after the last change.

## Structure
- Package open_list_pkg holds:
  - field-offset localparams for f, h, g, row, col and valid (derived from the widths);
  - the state enum {EMPTY, REFRESH, READY};
  - a function better(a, b) implementing the ordering, including index tie-break.
- One sub-module: pq_argmin, a combinational tree over DEPTH slots returning the winning index and a found flag.

## Test plan
- Reset, then push lanes f/h=(20/9),(15/7),(15/5),(0/0 invalid) → count=3 after 1 cycle; head_valid=1 after 2 cycles with f=15, h=5.
- Push cell (3,4) with f=30, then push (3,4) with f=25 → count stays 1, head f=25. Then push (3,4) with f=40 → no change.
- Fill DEPTH=16, then push 2 new valid lanes → full=1, count=16, overflow=1 and stays 1 until flush.
- Entries f=10/h=3 in slot 5 and f=10/h=3 in slot 2 → head is slot 2. Pop → next head is slot 5, two cycles later.
- Push and pop in the same cycle with count=16 → pop is applied, the lane is dropped, overflow=1, count=15.
- flush together with push in the same cycle → count=0, empty=1, head_valid=0 next cycle. Assert rst_n=0 mid-REFRESH → all outputs return to reset values immediately.
